hi_lo_muldiv_unit: RTL and testbench

Iterative multiply/divide engine owning the architectural HI and LO registers of the MIPS CPU. Sits in the execute stage directly downstream of the control unit: it consumes the decoded `hi_lo_register_write` strobe and the 6-bit `ALU_function` (R-type funct) together with the rs/rt operands. It executes MULT, MULTU, DIV, DIVU over multiple cycles, raising `busy` so the pipeline stalls, and performs single-cycle MTHI/MTLO writes. HI/LO are always visible for MFHI/MFLO.

---
 rtl/hi_lo_muldiv_unit_if.sv | 13 +
 rtl/hi_lo_muldiv_unit.sv | 76 +++++++
 tb/tb_hi_lo_muldiv_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/hi_lo_muldiv_unit_if.sv
// hi_lo_muldiv_unit_if: request/result bundle between control unit (master) and HI/LO mul/div engine (slave)
interface hi_lo_muldiv_unit_if;
  logic        start;
  logic [5:0]  ALU_function;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, ALU_function, operand_a, operand_b, input busy, done, hi, lo);
  modport slave (input start, ALU_function, operand_a, operand_b, output busy, done, hi, lo);
endinterface

// File: rtl/hi_lo_muldiv_unit.sv
// hi_lo_muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine owning HI/LO, plus single-cycle MTHI/MTLO (ports: clk, reset, bus.slave)
module hi_lo_muldiv_unit (
  input logic clk,
  input logic reset,
  hi_lo_muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_nx;
  logic [63:0] acc, mul_step, div_step, prod;
  logic [32:0] trial, sum;
  logic [31:0] opr, abs_a, abs_b, res_hi, res_lo;
  logic [4:0] cnt;
  logic is_div, neg_q, neg_r, div0;
  logic op_md, op_signed, op_div, mthi, mtlo, accept;
  // funct 0110xx: bit1 selects divide, bit0 selects unsigned
  always_comb begin
    op_md = bus.ALU_function[5:2] == 4'b0110;
    op_signed = !bus.ALU_function[0];
    op_div = bus.ALU_function[1];
    mthi = bus.ALU_function == 6'b010001;
    mtlo = bus.ALU_function == 6'b010011;
    accept = state == IDLE && bus.start && op_md;
    abs_a = (op_signed && bus.operand_a[31]) ? -bus.operand_a : bus.operand_a;
    abs_b = (op_signed && bus.operand_b[31]) ? -bus.operand_b : bus.operand_b;
    state_nx = state == IDLE ? (accept ? RUN : IDLE) : state == RUN ? (cnt == 5'd31 ? FIX : RUN) : IDLE;
    // acc = {remainder, dividend/quotient}; a borrow in bit 32 means the divisor did not fit
    trial = acc[63:31] - {1'b0, opr};
    div_step = trial[32] ? {acc[62:0], 1'b0} : {trial[31:0], acc[30:0], 1'b1};
    // acc = {partial product, remaining multiplier bits}, shifted right each step
    sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opr} : 33'd0);
    mul_step = {sum, acc[31:1]};
    prod = neg_q ? -acc : acc;
    // divide by zero naturally leaves remainder = dividend; only the quotient needs forcing
    res_hi = is_div ? (neg_r ? -acc[63:32] : acc[63:32]) : prod[63:32];
    res_lo = is_div ? (div0 ? 32'hFFFF_FFFF : neg_q ? -acc[31:0] : acc[31:0]) : prod[31:0];
    bus.busy = state != IDLE;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      bus.done <= 1'b0;
      bus.hi <= '0;
      bus.lo <= '0;
      acc <= '0;
      opr <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0 <= 1'b0;
    end else begin
      bus.done <= state == FIX;
      if (accept) begin
        cnt <= '0;
        acc <= {32'd0, op_div ? abs_a : abs_b};
        opr <= op_div ? abs_b : abs_a;
        is_div <= op_div;
        neg_q <= op_signed && (bus.operand_a[31] ^ bus.operand_b[31]);
        neg_r <= op_signed && op_div && bus.operand_a[31];
        div0 <= op_div && bus.operand_b == 32'd0;
      end
      if (state == IDLE && bus.start && mthi) bus.hi <= bus.operand_a;
      if (state == IDLE && bus.start && mtlo) bus.lo <= bus.operand_a;
      if (state == RUN) begin
        cnt <= cnt + 5'd1;
        acc <= is_div ? div_step : mul_step;
      end
      if (state == FIX) begin
        bus.hi <= res_hi;
        bus.lo <= res_lo;
      end
    end
  end
endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
// tb_hi_lo_muldiv_unit: scoreboard bench; stimulus queues expected {hi,lo}, monitor compares on each done pulse
module tb_hi_lo_muldiv_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int passed = 0;
  int done_seen = 0;
  logic [63:0] exp_q[$];
  string name_q[$];
  localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;
  localparam logic [5:0] MTHI = 6'b010001, MTLO = 6'b010011, ADD = 6'b100000;
  hi_lo_muldiv_unit_if bus();
  hi_lo_muldiv_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  always @(negedge clk)
    if (!reset && bus.done === 1'b1) begin
      done_seen++;
      if (exp_q.size() == 0) check("unexpected done", {bus.hi, bus.lo}, 64'hx);
      else check(name_q.pop_front(), {bus.hi, bus.lo}, exp_q.pop_front());
    end
  task automatic run_md(input string nm, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input bit inject);
    int n;
    bit held;
    logic [31:0] h0, l0;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(negedge clk);
    h0 = bus.hi;
    l0 = bus.lo;
    bus.start = 1'b1;
    bus.ALU_function = fn;
    bus.operand_a = a;
    bus.operand_b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.operand_a = ~a;
    bus.operand_b = 32'h5A5A_0001;
    n = 0;
    held = 1'b1;
    @(negedge clk);
    while (bus.busy && n < 100) begin
      n++;
      if (bus.hi !== h0 || bus.lo !== l0) held = 1'b0;
      if (inject && n == 5) begin
        bus.start = 1'b1;
        bus.ALU_function = MTLO;
        bus.operand_a = 32'h0000_DEAD;
      end else if (inject && n == 6) bus.start = 1'b0;
      @(negedge clk);
    end
    check({nm, " busy cycles"}, 64'(n), 64'd33);
    check({nm, " hold"}, 64'(held), 64'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    bus.start = 1'b0;
    bus.ALU_function = '0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset hilo", {bus.hi, bus.lo}, 64'd0);
    run_md("MULTU ffffffff^2", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    run_md("MULT -3*5", MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
    run_md("MULT min*min", MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
    run_md("DIV -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run_md("DIV 7/-2", DIV, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0);
    run_md("DIVU 7/2", DIVU, 32'd7, 32'd2, 64'h0000_0001_0000_0003, 1'b0);
    run_md("DIV min/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
    run_md("DIVU x/0", DIVU, 32'h1234_5678, 32'd0, 64'h1234_5678_FFFF_FFFF, 1'b0);
    run_md("DIV -7/0", DIV, 32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_FFFF_FFFF, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.ALU_function = MTHI;
    bus.operand_a = 32'hAAAA_5555;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check("MTHI hi", 64'(bus.hi), 64'hAAAA_5555);
    check("MTHI busy", 64'(bus.busy), 64'd0);
    bus.start = 1'b1;
    bus.ALU_function = ADD;
    bus.operand_a = 32'h7777_7777;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check("ignored funct busy", 64'(bus.busy), 64'd0);
    check("ignored funct hilo", {bus.hi, bus.lo}, {32'hAAAA_5555, 32'hFFFF_FFFF});
    run_md("MULTU 3*4 with MTLO during busy", MULTU, 32'd3, 32'd4, 64'h0000_0000_0000_000C, 1'b1);
    @(negedge clk);
    check("MTLO during busy ignored", {bus.hi, bus.lo}, 64'h0000_0000_0000_000C);
    bus.start = 1'b1;
    bus.ALU_function = DIV;
    bus.operand_a = 32'd100;
    bus.operand_b = 32'd7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("busy before abort", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort done", 64'(bus.done), 64'd0);
    check("abort hilo", {bus.hi, bus.lo}, 64'd0);
    repeat (40) @(negedge clk);
    run_md("MULTU 2*3 after abort", MULTU, 32'd2, 32'd3, 64'd6, 1'b0);
    repeat (5) @(negedge clk);
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    check("done pulse count", 64'(done_seen), 64'd11);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
